namco06xx_io_ctrl: RTL and testbench
====================================

// Module: namco06xx_io_ctrl
// PURPOSE
//  Namco 06XX-style I/O controller on the shared device bus (DEV_*) driven by the 3-CPU arbiter.
//  Decodes a data and a control register, runs a periodic timer that requests CPU0 NMI, and on
//  each tick sequences one byte transfer (read or write) with a selected custom I/O chip (51XX/53XX).
// PARAMETERS
//  BASE_ADDR  16'h7000  bus base; data reg = BASE+0x000..0x0FF, control reg = BASE+0x100..0x1FF
//  TICK_DIV   4800      CE cycles per timer unit (200 us at 24 MHz CE rate); range 2..65535
// PORTS
//  MCLK      in   1   system clock (48 MHz); all logic on posedge
//  RESET_N   in   1   synchronous reset, active-low
//  CE        in   1   bus clock enable, one MCLK pulse per DEV_CL rising edge
//  DEV_AD    in   16  bus address from arbiter
//  DEV_RD    in   1   bus read request
//  DEV_WR    in   1   bus write request
//  DEV_DI    in   8   bus write data
//  DEV_DV    out  1   read-data valid for this block (combinational)
//  DEV_DO    out  8   read data (combinational mux of registers; 0 when DEV_DV=0)
//  NMI_REQ   out  1   level NMI request to CPU0 NMI-ack logic
//  CHIP_SEL  out  4   one-hot chip select, registered
//  CHIP_RD   out  1   chip read strobe, registered
//  CHIP_WR   out  1   chip write strobe, registered
//  CHIP_DI   out  8   data to chip, registered
//  CHIP_DO   in   8   data from selected chip (muxed externally)
// BEHAVIOUR
//  Reset (RESET_N=0 at posedge MCLK): ctrl=0, data=0, timer=0, FSM=IDLE, NMI_REQ=0, CHIP_SEL=0,
//   CHIP_RD=0, CHIP_WR=0, CHIP_DI=0; DEV_DV/DEV_DO therefore 0. Reset mid-transfer aborts at once.
//  Decode: hit = DEV_AD[15:9]==BASE_ADDR[15:9]; AD[8]=0 data reg, AD[8]=1 control reg.
//  Reads: DEV_DV = hit & DEV_RD; DEV_DO = AD[8] ? ctrl : data. Zero latency, no state change
//   except NMI ack below.
//  Writes: taken only when CE & hit & DEV_WR (one write per bus slot).
//  Control write: ctrl<=DEV_DI; timer<=0; NMI_REQ<=0; FSM forced to IDLE, strobes/CHIP_SEL<=0.
//   ctrl[3:0]=chip one-hot select, ctrl[4]=1 read / 0 write, ctrl[7:5]=interval N.
//   N==0 -> timer halted (e.g. 8'h10 = stop).
//  Timer: counts CE pulses when N!=0; period P = N*TICK_DIV (17-bit+ product, no truncation).
//   On CE with timer==P-1: timer<=0, tick. Otherwise timer+1.
//  Tick: NMI_REQ<=1; if FSM==IDLE start transfer, else transfer skipped (NMI still raised).
//  NMI ack: CE & hit & AD[8]==0 & (DEV_RD|DEV_WR) clears NMI_REQ. Tick on same CE wins (stays 1).
//  Transfer FSM (advances only on CE):
//   IDLE  -> SETUP : on tick. CHIP_SEL<=ctrl[3:0]; CHIP_DI<=data (write mode).
//   SETUP -> STRB1 : CHIP_RD<=ctrl[4]; CHIP_WR<=~ctrl[4].
//   STRB1 -> STRB2 : strobe held.
//   STRB2 -> HOLD  : strobes<=0; read mode: data<=CHIP_DO (captured this CE).
//   HOLD  -> IDLE  : CHIP_SEL<=0.
//   Transfer = 4 CE from tick to CHIP_SEL release; strobe width exactly 2 CE.
//  ctrl[3:0]==0: FSM still runs, CHIP_SEL stays 0, strobes suppressed, no capture.
//  CPU data write same CE as read capture: capture wins. CPU data write during STRB* in write
//   mode updates data only; CHIP_DI keeps value latched in SETUP.
//  P < 5 (only if TICK_DIV<5, N=1): ticks during non-IDLE skip the transfer as above.
// TESTING
//  1 Reset: hold RESET_N=0 mid-STRB1 -> next posedge all outputs 0, FSM IDLE, NMI_REQ 0.
//  2 Write 8'h21 to 0x7100, 0xA5 to 0x7000, TICK_DIV=8 -> NMI_REQ rises after 8 CE;
//    CHIP_SEL=4'h1, CHIP_WR high exactly 2 CE, CHIP_DI=8'hA5.
//  3 Write 8'h52 to 0x7100, CHIP_DO=8'h3C -> CHIP_RD 2 CE on chip 4'h2; read 0x7000 gives 8'h3C,
//    DEV_DV=1, NMI_REQ cleared by that read.
//  4 N=3, TICK_DIV=8 -> ticks every 24 CE exactly; write 8'h10 -> no further NMI/strobes.
//  5 Ack read of 0x7000 on same CE as tick -> NMI_REQ remains 1.
//  6 Read 0x7100 returns last ctrl; address 0x7200 -> DEV_DV=0, DEV_DO=0, no state change.

Source files
------------

// File: rtl/namco06xx_io_ctrl.sv
// -----------------------------------------------------------------------------
// namco06xx_io_ctrl
//
// A Namco 06XX-style I/O controller that sits on the shared device bus
// (DEV_*). The bus is driven by the 3-CPU arbiter.
//
// What the block does:
//   - Decodes two registers. The data register is at BASE+0x000..0x0FF and
//     the control register is at BASE+0x100..0x1FF.
//   - Runs a periodic timer. Each timer tick raises NMI_REQ to CPU0.
//   - On each tick, runs one byte transfer (read or write) with the custom
//     I/O chip selected in ctrl[3:0].
//
// Control register layout:
//   ctrl[3:0]  one-hot chip select
//   ctrl[4]    1 = read from chip, 0 = write to chip
//   ctrl[7:5]  interval N; N == 0 halts the timer
//
// Ports:
//   MCLK       system clock (48 MHz); all logic on posedge
//   RESET_N    synchronous reset, active-low
//   CE         bus clock enable, one MCLK pulse per bus slot
//   DEV_AD     bus address
//   DEV_RD     bus read request
//   DEV_WR     bus write request
//   DEV_DI     bus write data
//   DEV_DV     read-data valid (combinational)
//   DEV_DO     read data (combinational; 0 when DEV_DV = 0)
//   NMI_REQ    level NMI request to CPU0
//   CHIP_SEL   one-hot chip select (registered)
//   CHIP_RD    chip read strobe (registered)
//   CHIP_WR    chip write strobe (registered)
//   CHIP_DI    data to the chip (registered)
//   CHIP_DO    data from the selected chip
// -----------------------------------------------------------------------------
module namco06xx_io_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int          TICK_DIV  = 4800
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic [15:0] DEV_AD,
    input  logic        DEV_RD,
    input  logic        DEV_WR,
    input  logic [7:0]  DEV_DI,
    output logic        DEV_DV,
    output logic [7:0]  DEV_DO,
    output logic        NMI_REQ,
    output logic [3:0]  CHIP_SEL,
    output logic        CHIP_RD,
    output logic        CHIP_WR,
    output logic [7:0]  CHIP_DI,
    input  logic [7:0]  CHIP_DO
);

    // 7 * 65535 needs 19 bits. The product is kept at full width.
    localparam int            PW         = 19;
    localparam logic [PW-1:0] TICK_DIV_W = PW'(TICK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STRB1,
        ST_STRB2,
        ST_HOLD
    } state_t;

    state_t        state_reg;
    logic [7:0]    ctrl_reg;
    logic [7:0]    data_reg;
    logic [PW-1:0] timer_reg;
    logic          nmi_reg;
    logic [3:0]    sel_reg;
    logic          rd_reg;
    logic          wr_reg;
    logic [7:0]    di_reg;

    logic          hit;
    logic          ctrl_wr;
    logic          data_wr;
    logic          nmi_ack;
    logic          timer_run;
    logic          tick;
    logic          sel_any;
    logic [PW-1:0] period;

    // Address decode and bus strobes.
    assign hit     = (DEV_AD[15:9] == BASE_ADDR[15:9]);
    assign ctrl_wr = CE & hit & DEV_WR &  DEV_AD[8];
    assign data_wr = CE & hit & DEV_WR & ~DEV_AD[8];
    assign nmi_ack = CE & hit & ~DEV_AD[8] & (DEV_RD | DEV_WR);

    // Timer period and tick detection.
    assign period    = {16'b0, ctrl_reg[7:5]} * TICK_DIV_W;
    assign timer_run = (ctrl_reg[7:5] != 3'd0);
    // A control write on the same CE restarts the timer, so it masks the tick.
    assign tick      = CE & ~ctrl_wr & timer_run & (timer_reg == period - PW'(1));
    assign sel_any   = |ctrl_reg[3:0];

    // Zero-latency register read port.
    assign DEV_DV = hit & DEV_RD;
    assign DEV_DO = DEV_DV ? (DEV_AD[8] ? ctrl_reg : data_reg) : 8'h00;

    assign NMI_REQ  = nmi_reg;
    assign CHIP_SEL = sel_reg;
    assign CHIP_RD  = rd_reg;
    assign CHIP_WR  = wr_reg;
    assign CHIP_DI  = di_reg;

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_reg <= ST_IDLE;
            ctrl_reg  <= 8'h00;
            data_reg  <= 8'h00;
            timer_reg <= '0;
            nmi_reg   <= 1'b0;
            sel_reg   <= 4'h0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            di_reg    <= 8'h00;
        end else begin
            // A chip read capture later in this block overrides this write.
            if (data_wr)
                data_reg <= DEV_DI;

            if (ctrl_wr) begin
                // A new control word aborts any transfer in flight.
                ctrl_reg  <= DEV_DI;
                timer_reg <= '0;
                nmi_reg   <= 1'b0;
                state_reg <= ST_IDLE;
                sel_reg   <= 4'h0;
                rd_reg    <= 1'b0;
                wr_reg    <= 1'b0;
            end else if (CE) begin
                if (timer_run)
                    timer_reg <= tick ? '0 : timer_reg + PW'(1);

                // If a tick and an ack land on the same CE, the tick wins.
                if (tick)
                    nmi_reg <= 1'b1;
                else if (nmi_ack)
                    nmi_reg <= 1'b0;

                case (state_reg)
                    ST_IDLE: begin
                        if (tick) begin
                            state_reg <= ST_SETUP;
                            sel_reg   <= ctrl_reg[3:0];
                            if (!ctrl_reg[4])
                                di_reg <= data_reg;
                        end
                    end
                    ST_SETUP: begin
                        // With no chip selected, the sequence still runs
                        // but no strobe is driven.
                        rd_reg    <=  ctrl_reg[4] & sel_any;
                        wr_reg    <= ~ctrl_reg[4] & sel_any;
                        state_reg <= ST_STRB1;
                    end
                    ST_STRB1: begin
                        state_reg <= ST_STRB2;
                    end
                    ST_STRB2: begin
                        rd_reg <= 1'b0;
                        wr_reg <= 1'b0;
                        if (ctrl_reg[4] && sel_any)
                            data_reg <= CHIP_DO;
                        state_reg <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        sel_reg   <= 4'h0;
                        state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_namco06xx_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_namco06xx_io_ctrl
//
// Directed testbench for namco06xx_io_ctrl, built with TICK_DIV = 8.
//
// Each bus slot is two MCLK cycles:
//   - first cycle: CE = 1, with the bus request applied
//   - second cycle: CE = 0, bus idle
//
// Outputs are sampled 1 time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_namco06xx_io_ctrl;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic        CE;
    logic [15:0] DEV_AD;
    logic        DEV_RD;
    logic        DEV_WR;
    logic [7:0]  DEV_DI;
    logic        DEV_DV;
    logic [7:0]  DEV_DO;
    logic        NMI_REQ;
    logic [3:0]  CHIP_SEL;
    logic        CHIP_RD;
    logic        CHIP_WR;
    logic [7:0]  CHIP_DI;
    logic [7:0]  CHIP_DO;

    int errors = 0;
    int checks = 0;

    namco06xx_io_ctrl #(
        .BASE_ADDR(16'h7000),
        .TICK_DIV (8)
    ) dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .CE      (CE),
        .DEV_AD  (DEV_AD),
        .DEV_RD  (DEV_RD),
        .DEV_WR  (DEV_WR),
        .DEV_DI  (DEV_DI),
        .DEV_DV  (DEV_DV),
        .DEV_DO  (DEV_DO),
        .NMI_REQ (NMI_REQ),
        .CHIP_SEL(CHIP_SEL),
        .CHIP_RD (CHIP_RD),
        .CHIP_WR (CHIP_WR),
        .CHIP_DI (CHIP_DI),
        .CHIP_DO (CHIP_DO)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One bus slot (CE cycle followed by a quiet cycle).
    task automatic slot(input logic [15:0] ad, input logic rd, input logic wr, input logic [7:0] di);
        DEV_AD = ad;
        DEV_RD = rd;
        DEV_WR = wr;
        DEV_DI = di;
        CE     = 1'b1;
        @(posedge MCLK);
        #1;
        CE     = 1'b0;
        DEV_RD = 1'b0;
        DEV_WR = 1'b0;
        DEV_AD = 16'h0000;
        @(posedge MCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            slot(16'h0000, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr8(input logic [15:0] ad, input logic [7:0] di);
        slot(ad, 1'b0, 1'b1, di);
    endtask

    // Read slot: checks the combinational read port before the CE edge.
    task automatic rd_chk(input string tag, input logic [15:0] ad, input logic dv, input logic [7:0] dout);
        DEV_AD = ad;
        DEV_RD = 1'b1;
        DEV_WR = 1'b0;
        CE     = 1'b1;
        #1;
        chk({tag, "_dv"}, 32'(DEV_DV), 32'(dv));
        chk({tag, "_do"}, 32'(DEV_DO), 32'(dout));
        @(posedge MCLK);
        #1;
        CE     = 1'b0;
        DEV_RD = 1'b0;
        DEV_AD = 16'h0000;
        @(posedge MCLK);
        #1;
    endtask

    initial begin
        int first_tick;
        int second_tick;
        int tick_cnt;
        int activity;

        RESET_N = 1'b0;
        CE      = 1'b0;
        DEV_AD  = 16'h0000;
        DEV_RD  = 1'b0;
        DEV_WR  = 1'b0;
        DEV_DI  = 8'h00;
        CHIP_DO = 8'h00;

        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_nmi", 32'(NMI_REQ), 0);
        chk("rst_sel", 32'(CHIP_SEL), 0);
        RESET_N = 1'b1;
        @(posedge MCLK);
        #1;

        // Write-mode transfer: chip 1, N = 1, period = 8 CE.
        wr8(16'h7000, 8'hA5);
        wr8(16'h7100, 8'h21);
        idle(7);
        chk("t2_nmi_before", 32'(NMI_REQ), 0);
        idle(1);
        chk("t2_nmi_tick", 32'(NMI_REQ), 1);
        chk("t2_sel", 32'(CHIP_SEL), 32'h1);
        chk("t2_wr_setup", 32'(CHIP_WR), 0);
        chk("t2_di", 32'(CHIP_DI), 32'hA5);
        idle(1);
        chk("t2_wr_1", 32'(CHIP_WR), 1);
        chk("t2_rd_1", 32'(CHIP_RD), 0);
        idle(1);
        chk("t2_wr_2", 32'(CHIP_WR), 1);
        idle(1);
        chk("t2_wr_off", 32'(CHIP_WR), 0);
        chk("t2_sel_hold", 32'(CHIP_SEL), 32'h1);
        idle(1);
        chk("t2_sel_rel", 32'(CHIP_SEL), 0);

        // Read-mode transfer: chip 2, N = 2, period = 16 CE.
        CHIP_DO = 8'h3C;
        wr8(16'h7100, 8'h52);
        chk("t3_nmi_clr", 32'(NMI_REQ), 0);
        idle(15);
        chk("t3_nmi_before", 32'(NMI_REQ), 0);
        idle(1);
        chk("t3_nmi_tick", 32'(NMI_REQ), 1);
        chk("t3_sel", 32'(CHIP_SEL), 32'h2);
        idle(1);
        chk("t3_rd_1", 32'(CHIP_RD), 1);
        chk("t3_wr_1", 32'(CHIP_WR), 0);
        idle(1);
        chk("t3_rd_2", 32'(CHIP_RD), 1);
        idle(1);
        chk("t3_rd_off", 32'(CHIP_RD), 0);
        rd_chk("t3_read", 16'h7000, 1'b1, 8'h3C);
        chk("t3_nmi_ack", 32'(NMI_REQ), 0);
        chk("t3_sel_rel", 32'(CHIP_SEL), 0);

        // N = 3, period = 24 CE. Ack-read every slot: a tick on the same CE
        // as an ack must keep NMI_REQ high.
        wr8(16'h7100, 8'h61);
        first_tick  = 0;
        second_tick = 0;
        tick_cnt    = 0;
        for (int i = 1; i <= 60; i++) begin
            slot(16'h7000, 1'b1, 1'b0, 8'h00);
            if (NMI_REQ) begin
                tick_cnt++;
                if (first_tick == 0)
                    first_tick = i;
                else if (second_tick == 0)
                    second_tick = i;
            end
        end
        chk("t4_first_tick", 32'(first_tick), 24);
        chk("t4_second_tick", 32'(second_tick), 48);
        chk("t5_tick_beats_ack", 32'(tick_cnt), 2);

        // Stop the timer: no further NMI requests or strobes.
        wr8(16'h7100, 8'h10);
        chk("t4_stop_nmi", 32'(NMI_REQ), 0);
        activity = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if (NMI_REQ || CHIP_RD || CHIP_WR || (CHIP_SEL != 4'h0))
                activity++;
        end
        chk("t4_stop_quiet", 32'(activity), 0);

        // Register readback, and accesses to addresses outside the block.
        rd_chk("t6_ctrl", 16'h7100, 1'b1, 8'h10);
        rd_chk("t6_miss", 16'h7200, 1'b0, 8'h00);
        wr8(16'h7200, 8'hFF);
        wr8(16'h7300, 8'h21);
        rd_chk("t6_ctrl_after", 16'h7100, 1'b1, 8'h10);
        rd_chk("t6_data_after", 16'h7000, 1'b1, 8'h3C);

        // A chip read capture beats a CPU data write on the same CE.
        CHIP_DO = 8'h5A;
        wr8(16'h7100, 8'h32);
        idle(8);
        chk("cap_nmi_tick", 32'(NMI_REQ), 1);
        idle(2);
        wr8(16'h7000, 8'h77);
        rd_chk("cap_wins", 16'h7000, 1'b1, 8'h5A);

        // A CPU data write during a write strobe leaves CHIP_DI unchanged.
        wr8(16'h7000, 8'h11);
        wr8(16'h7100, 8'h21);
        idle(8);
        chk("di_latch", 32'(CHIP_DI), 32'h11);
        idle(1);
        wr8(16'h7000, 8'h99);
        chk("di_keep", 32'(CHIP_DI), 32'h11);
        chk("di_wr_strobe", 32'(CHIP_WR), 1);
        rd_chk("di_data_upd", 16'h7000, 1'b1, 8'h99);

        // Reset asserted in the middle of STRB1.
        wr8(16'h7100, 8'h21);
        idle(9);
        chk("rst_pre_wr", 32'(CHIP_WR), 1);
        chk("rst_pre_di", 32'(CHIP_DI), 32'h99);
        RESET_N = 1'b0;
        @(posedge MCLK);
        #1;
        chk("rst_mid_nmi", 32'(NMI_REQ), 0);
        chk("rst_mid_sel", 32'(CHIP_SEL), 0);
        chk("rst_mid_wr", 32'(CHIP_WR), 0);
        chk("rst_mid_rd", 32'(CHIP_RD), 0);
        chk("rst_mid_di", 32'(CHIP_DI), 0);
        DEV_AD = 16'h7100;
        DEV_RD = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'(DEV_DO), 0);
        DEV_AD = 16'h7000;
        #1;
        chk("rst_mid_data", 32'(DEV_DO), 0);
        DEV_RD = 1'b0;
        RESET_N = 1'b1;
        @(posedge MCLK);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
